// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: mem_op field positions, size codes, FSM encoding and lane helpers.
package mem_stage_pkg;
  localparam int OP_STORE = 4;
  localparam int OP_LOAD = 3;
  localparam int OP_UNS = 2;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_X || (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
  endfunction
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_B ? 4'b0001 << off : size == SZ_H ? 4'b0011 << off : 4'b1111;
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/response bus between mem_stage and memory.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  modport master(output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                 input dmem_gnt, dmem_rvalid, dmem_rdata);
  modport slave(input dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed byte/half of a read word and sign/zero-extends it.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [15:0] sh;
  assign sh = 16'(rdata >> {off, 3'b000});
  always_comb
    data = size == SZ_B ? {{24{~uns & sh[7]}}, sh[7:0]} :
           size == SZ_H ? {{16{~uns & sh[15]}}, sh} : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage issuing loads/stores on the dmem bus and
// producing a registered writeback bundle.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  mem_op,
  input  logic        rd_en,
  input  logic [4:0]  rd,
  input  logic [31:0] exresult,
  input  logic [31:0] result_address,
  output logic        stall_mem,
  mem_stage_if.master bus,
  output logic        wb_valid,
  output logic        wb_rd_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] memdata,
  output logic        misalign
);
  state_t      state_q;
  logic [4:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [4:0]  rd_q;
  logic        rd_en_q;
  logic        wb_valid_q;
  logic        wb_rd_en_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        misalign_q;
  logic        is_mem;
  logic        bad;
  logic        req;
  logic [31:0] ld_data;

  assign is_mem = mem_op[OP_STORE] | mem_op[OP_LOAD];
  assign bad = misaligned(mem_op[1:0], result_address[1:0]);
  assign req = state_q == S_REQ;
  assign stall_mem = state_q != S_IDLE;
  assign bus.dmem_req = req;
  assign bus.dmem_we = req & op_q[OP_STORE];
  assign bus.dmem_be = req ? lane_be(op_q[1:0], addr_q[1:0]) : 4'b0000;
  assign bus.dmem_addr = {addr_q[31:2], 2'b00};
  assign bus.dmem_wdata = op_q[1:0] == SZ_B ? {4{data_q[7:0]}} :
                          op_q[1:0] == SZ_H ? {2{data_q[15:0]}} : data_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd_en = wb_rd_en_q;
  assign wb_rd = wb_rd_q;
  assign wb_data = wb_data_q;
  assign memdata = wb_data_q;
  assign misalign = misalign_q;

  load_align u_align (
    .rdata(bus.dmem_rdata),
    .off  (addr_q[1:0]),
    .size (op_q[1:0]),
    .uns  (op_q[OP_UNS]),
    .data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      rd_en_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_en_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE:
          if (in_valid && !is_mem) begin
            wb_valid_q <= 1'b1;
            wb_rd_en_q <= rd_en && rd != 5'd0;
            wb_rd_q    <= rd;
            wb_data_q  <= exresult;
          end else if (in_valid && bad) begin
            wb_valid_q <= 1'b1;
            misalign_q <= 1'b1;
            wb_rd_en_q <= 1'b0;
            wb_rd_q    <= rd;
          end else if (in_valid) begin
            op_q    <= mem_op;
            addr_q  <= result_address;
            data_q  <= exresult;
            rd_q    <= rd;
            rd_en_q <= rd_en;
            state_q <= S_REQ;
          end
        S_REQ:
          if (bus.dmem_gnt && op_q[OP_STORE]) begin
            wb_valid_q <= 1'b1;
            wb_rd_en_q <= 1'b0;
            wb_rd_q    <= rd_q;
            state_q    <= S_IDLE;
          end else if (bus.dmem_gnt) begin
            state_q <= S_WAIT;
          end
        S_WAIT:
          if (bus.dmem_rvalid) begin
            wb_valid_q <= 1'b1;
            wb_rd_en_q <= rd_en_q && rd_q != 5'd0;
            wb_rd_q    <= rd_q;
            wb_data_q  <= ld_data;
            state_q    <= S_IDLE;
          end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 in_valid  in  1  execute stage presents an instruction this cycle.
REQ-004 mem_op  in  5  [4]=store, [3]=load, [2]=unsigned load, [1:0]=size (00 byte, 01 half, 10 word, 11 illegal).
REQ-005 rd_en, rd  in  1, 5  destination-register write enable and index.
REQ-006 exresult  in  32  ALU result; store data for stores.
REQ-007 result_address  in  32  effective address for load/store.
REQ-008 stall_mem  out  1  holds execute and upstream stages.
REQ-009 dmem_req, dmem_we  out  1, 1  bus request; write qualifier.
REQ-010 dmem_addr, dmem_wdata, dmem_be  out  32, 32, 4  word-aligned address, lane-shifted data, byte enables.
REQ-011 dmem_gnt, dmem_rvalid, dmem_rdata  in  1, 1, 32  request accepted; read data valid; read word.
REQ-012 wb_valid, wb_rd_en, wb_rd, wb_data  out  1, 1, 5, 32  registered writeback bundle.
REQ-013 memdata  out  32  equals wb_data; forwarding path to execute.
REQ-014 misalign  out  1  one-cycle pulse with wb_valid for a misaligned or illegal-size access.

Function
REQ-015 FSM states: IDLE, REQ, WAIT. Instruction accepted only in IDLE when in_valid=1.
REQ-016 Non-memory op in IDLE: wb_* registered next cycle (1-cycle latency); state stays IDLE.
REQ-017 Memory op in IDLE: op, address, data, rd latched; next state REQ.
REQ-018 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0, size 11): no bus request; wb_valid and misalign next cycle; wb_rd_en=0; state stays IDLE.
REQ-019 REQ: dmem_req=1 with stable addr/we/be/wdata until dmem_gnt=1 is sampled.
REQ-020 Store with gnt: wb_valid=1 and wb_rd_en=0 next cycle; go IDLE.
REQ-021 Load with gnt: go WAIT; dmem_rvalid asserted in the same cycle as gnt is ignored (earliest legal rvalid is the next cycle).
REQ-022 WAIT: on dmem_rvalid, byte/half selected by addr[1:0], sign- or zero-extended per mem_op[2]; wb_valid=1 with data next cycle; go IDLE.
REQ-023 dmem_addr = {addr[31:2],2'b00}; dmem_be: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111; wdata replicated into selected lanes.
REQ-024 stall_mem = 1 whenever state is REQ or WAIT (combinational from state); 0 in IDLE.
REQ-025 wb_valid is a single-cycle pulse per retired instruction; wb_* hold their last value while wb_valid=0.
REQ-026 rd_en with rd=0 retires with wb_rd_en=0.
REQ-027 Back-to-back non-memory ops retire one per cycle with no bubble.

Reset
REQ-028 rst returns state to IDLE in the same edge, including mid-REQ or mid-WAIT; a pending transaction is abandoned and late rvalid is ignored.
REQ-029 After reset: stall_mem=0, dmem_req=0, dmem_we=0, dmem_be=0, wb_valid=0, wb_rd_en=0, misalign=0, wb_data=0, wb_rd=0.

Structure
REQ-030 Shared package holds mem_op field positions, size codes, and FSM state encoding.
REQ-031 One sub-module, load_align: combinational lane select and sign/zero extension.

Verification
REQ-032 ADD (rd=5, exresult=0x12345678) -> next cycle wb_valid=1, wb_rd=5, wb_data=0x12345678, stall_mem=0.
REQ-033 Signed byte load, addr 0x103, gnt immediate, rdata=0x80FF_FF7F at rvalid one cycle later -> wb_data=0xFFFFFF80.
REQ-034 Store half, addr 0x102, data 0xABCD, gnt delayed 3 cycles -> be=1100, wdata=0xABCDABCD, dmem_addr=0x100, stall_mem high for 4 cycles.
REQ-035 Word load at addr 0x101 -> no dmem_req; misalign=1, wb_valid=1, wb_rd_en=0.
REQ-036 rst asserted in WAIT, rvalid arrives one cycle later -> no wb_valid, state IDLE, stall_mem=0.
REQ-037 Unsigned half load, addr 0x102, rdata=0x8001_0000 -> wb_data=0x00008001.
